// File: rtl/jk_pkg.sv
// jk_pkg: shared types and helpers for the JK flip-flop command driver.
//   jk_cmd_t    - 2-bit command encoding, numerically equal to {j,k}
//   drv_state_t - driver FSM states
//   jk_drive_t  - {j,k} payload driven to the flip-flop
//   cmd_to_jk   - command to {j,k} mapping
//   next_exp    - expected flip-flop state after a command is applied
package jk_pkg;

  localparam int unsigned CMD_W = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_HOLD   = 2'b00,
    CMD_CLR    = 2'b01,
    CMD_SET    = 2'b10,
    CMD_TOGGLE = 2'b11
  } jk_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } drv_state_t;

  typedef struct packed {
    logic j;
    logic k;
  } jk_drive_t;

  // Map a command to the j/k levels presented to the flip-flop.
  function automatic jk_drive_t cmd_to_jk(input jk_cmd_t c);
    jk_drive_t d;
    d = '0;
    case (c)
      CMD_CLR:    begin d.j = 1'b0; d.k = 1'b1; end
      CMD_SET:    begin d.j = 1'b1; d.k = 1'b0; end
      CMD_TOGGLE: begin d.j = 1'b1; d.k = 1'b1; end
      default:    begin d.j = 1'b0; d.k = 1'b0; end
    endcase
    return d;
  endfunction

  // Model of the flip-flop: state after one clock with command c applied.
  function automatic logic next_exp(input logic cur, input jk_cmd_t c);
    logic n;
    n = cur;
    case (c)
      CMD_CLR:    n = 1'b0;
      CMD_SET:    n = 1'b1;
      CMD_TOGGLE: n = ~cur;
      default:    n = cur;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// jk_cmd_fifo: synchronous FIFO buffering JK commands.
//   clk, reset   - rising-edge clock, synchronous active-high reset (flush)
//   push, din    - write request and data; ignored while full
//   pop          - read request; ignored while empty
//   dout_c       - head entry (combinational read of the head slot)
//   full, empty  - registered status flags
// Pointers are log2(DEPTH) bits and wrap naturally; an extra count bit
// separates full from empty.
module jk_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout_c,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_n;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses pushes even when a pop happens on the same edge.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout_c  = mem[rd_ptr];

  // Occupancy after this edge; drives the registered flags.
  always_comb begin
    count_n = count;
    if (do_push && !do_pop) begin
      count_n = count + CW'(1);
    end else if (!do_push && do_pop) begin
      count_n = count - CW'(1);
    end
  end

  // Pointer, count and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_n;
      full  <= (count_n == CW'(DEPTH));
      empty <= (count_n == '0);
    end
  end

  // Storage; no reset needed since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/jk_cmd_driver.sv
// jk_cmd_driver: drives a JK flip-flop from a command stream and checks it.
//   clk, reset            - rising-edge clock, synchronous active-high reset
//                           (same net resets the flip-flop)
//   cmd_valid, cmd        - command handshake input (00 HOLD, 01 CLR,
//                           10 SET, 11 TOGGLE)
//   cmd_ready             - command FIFO not full
//   j, k                  - registered flip-flop inputs, one-cycle pulses
//   q_in                  - flip-flop output
//   exp_q                 - expected flip-flop state
//   busy                  - commands pending or FSM not idle
//   err, err_count        - sticky mismatch flag, saturating mismatch count
// Each command takes a DRIVE cycle (j/k asserted) then a CHECK cycle
// (q_in compared against exp_q).
module jk_cmd_driver
  import jk_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd,
  output logic             cmd_ready,
  output logic             j,
  output logic             k,
  input  logic             q_in,
  output logic             exp_q,
  output logic             busy,
  output logic             err,
  output logic [ERR_W-1:0] err_count
);

  drv_state_t       state;
  drv_state_t       state_n;
  jk_cmd_t          cur_cmd;
  jk_cmd_t          cur_cmd_n;
  logic             j_n;
  logic             k_n;
  logic             exp_q_n;
  logic             err_n;
  logic [ERR_W-1:0] err_count_n;

  logic             fifo_full;
  logic             fifo_empty;
  logic [CMD_W-1:0] head_c;
  logic             push_c;
  logic             pop_c;
  jk_cmd_t          head_cmd_c;
  jk_drive_t        head_drv_c;

  assign push_c     = cmd_valid & ~fifo_full;
  assign cmd_ready  = ~fifo_full;
  assign busy       = ~fifo_empty | (state != ST_IDLE);
  assign head_cmd_c = jk_cmd_t'(head_c);
  assign head_drv_c = cmd_to_jk(head_cmd_c);

  // Command buffer.
  jk_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push_c),
    .din    (cmd),
    .pop    (pop_c),
    .dout_c (head_c),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Next-state, j/k, expected-value and error logic.
  always_comb begin
    state_n     = state;
    cur_cmd_n   = cur_cmd;
    j_n         = 1'b0;
    k_n         = 1'b0;
    exp_q_n     = exp_q;
    err_n       = err;
    err_count_n = err_count;
    pop_c       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_c     = 1'b1;
          cur_cmd_n = head_cmd_c;
          j_n       = head_drv_c.j;
          k_n       = head_drv_c.k;
          state_n   = ST_DRIVE;
        end
      end

      // The flip-flop samples j/k at the edge closing this cycle; the
      // model advances on the same edge so both agree during CHECK.
      ST_DRIVE: begin
        exp_q_n = next_exp(exp_q, cur_cmd);
        state_n = ST_CHECK;
      end

      ST_CHECK: begin
        if (q_in != exp_q) begin
          err_n = 1'b1;
          if (err_count != '1) begin
            err_count_n = err_count + ERR_W'(1);
          end
        end
        if (!fifo_empty) begin
          pop_c     = 1'b1;
          cur_cmd_n = head_cmd_c;
          j_n       = head_drv_c.j;
          k_n       = head_drv_c.k;
          state_n   = ST_DRIVE;
        end else begin
          state_n = ST_IDLE;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cur_cmd   <= CMD_HOLD;
      j         <= 1'b0;
      k         <= 1'b0;
      exp_q     <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      cur_cmd   <= cur_cmd_n;
      j         <= j_n;
      k         <= k_n;
      exp_q     <= exp_q_n;
      err       <= err_n;
      err_count <= err_count_n;
    end
  end

endmodule

// File: tb/tb_jk_cmd_driver.sv
// tb_jk_cmd_driver: scoreboard bench for jk_cmd_driver driving a behavioural
// JK flip-flop. Stimulus pushes hand-computed {j,k, exp_q} entries; a monitor
// pops one per observed j/k pulse and checks exp_q in the following cycle.
module tb_jk_cmd_driver;

  localparam logic [1:0] C_HOLD = 2'b00;
  localparam logic [1:0] C_CLR  = 2'b01;
  localparam logic [1:0] C_SET  = 2'b10;
  localparam logic [1:0] C_TOG  = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic       cmd_ready;
  logic       j;
  logic       k;
  logic       q_in;
  logic       exp_q;
  logic       busy;
  logic       err;
  logic [1:0] err_count;

  logic ff_q;
  logic fault_en = 1'b0;
  logic fault_val = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stalls = 0;

  typedef struct packed {
    logic [1:0] jk;
    logic       exp;
  } sb_t;

  sb_t sb_q[$];
  int  pulse_cyc[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  jk_cmd_driver #(
    .DEPTH (4),
    .ERR_W (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_ready (cmd_ready),
    .j         (j),
    .k         (k),
    .q_in      (q_in),
    .exp_q     (exp_q),
    .busy      (busy),
    .err       (err),
    .err_count (err_count)
  );

  // Flip-flop under drive, with an override for fault injection.
  always @(posedge clk or posedge reset) begin
    if (reset) ff_q <= 1'b0;
    else begin
      case ({j, k})
        2'b01:   ff_q <= 1'b0;
        2'b10:   ff_q <= 1'b1;
        2'b11:   ff_q <= ~ff_q;
        default: ff_q <= ff_q;
      endcase
    end
  end
  assign q_in = fault_en ? fault_val : ff_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: one scoreboard entry per j/k pulse, exp_q checked next cycle.
  initial begin : monitor
    sb_t e;
    logic pend;
    logic pend_exp;
    pend = 1'b0;
    pend_exp = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        sb_q.delete();
        pend = 1'b0;
      end else if (pend) begin
        check("exp_q_after_pulse", 32'(exp_q), 32'(pend_exp));
        check("pulse_width", 32'({j, k}), 32'd0);
        pend = 1'b0;
      end else if ({j, k} != 2'b00) begin
        pulse_cyc.push_back(cyc);
        if (sb_q.size() == 0) begin
          check("extra_pulse", 32'({j, k}), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("jk_pulse", 32'({j, k}), 32'(e.jk));
          pend = 1'b1;
          pend_exp = e.exp;
        end
      end
    end
  end

  // Push one command, holding cmd_valid through any stall; returns accept cycle.
  task automatic push_cmd(input logic [1:0] c, input logic [1:0] ejk,
                          input logic eexp, output int acc);
    int guard;
    guard = 0;
    cmd_valid = 1'b1;
    cmd = c;
    while (!cmd_ready && guard < 50) begin
      stalls++;
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: cmd_ready stuck at 0 for %0d cycles, required 1", guard);
    end
    @(posedge clk);
    #1;
    acc = cyc;
    if (ejk != 2'b00) sb_q.push_back({ejk, eexp});
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy !== 1'b0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("drain_busy", 32'(busy), 32'd0);
  endtask

  // Full-FIFO sequence and hand-computed expectations.
  logic [1:0] f_cmd [8] = '{C_SET, C_CLR, C_TOG, C_TOG, C_SET, C_CLR, C_TOG, C_SET};
  logic [1:0] f_jk  [8] = '{2'b10, 2'b01, 2'b11, 2'b11, 2'b10, 2'b01, 2'b11, 2'b10};
  logic       f_exp [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin : stim
    int acc0;
    int dummy;
    int pulses;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_j", 32'(j), 32'd0);
    check("rst_k", 32'(k), 32'd0);
    check("rst_exp_q", 32'(exp_q), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // Back-to-back sequence with a healthy flip-flop.
    pulse_cyc.delete();
    push_cmd(C_SET, 2'b10, 1'b1, acc0);
    push_cmd(C_TOG, 2'b11, 1'b0, dummy);
    push_cmd(C_TOG, 2'b11, 1'b1, dummy);
    push_cmd(C_CLR, 2'b01, 1'b0, dummy);
    push_cmd(C_HOLD, 2'b00, 1'b0, dummy);
    wait_idle();
    check("seq_exp_q", 32'(exp_q), 32'd0);
    check("seq_err", 32'(err), 32'd0);
    check("seq_sb_empty", 32'(sb_q.size()), 32'd0);
    check("seq_pulse_count", 32'(pulse_cyc.size()), 32'd4);
    if (pulse_cyc.size() >= 4) begin
      check("seq_latency", 32'(pulse_cyc[0]), 32'(acc0 + 1));
      for (int i = 1; i < 4; i++)
        check("seq_pulse_gap", 32'(pulse_cyc[i] - pulse_cyc[i-1]), 32'd2);
    end

    // Full FIFO under continuous pushes.
    do_reset();
    stalls = 0;
    for (int i = 0; i < 7; i++) push_cmd(f_cmd[i], f_jk[i], f_exp[i], dummy);
    check("full_cmd_ready", 32'(cmd_ready), 32'd0);
    push_cmd(f_cmd[7], f_jk[7], f_exp[7], dummy);
    wait_idle();
    check("full_saw_stall", 32'(stalls > 0), 32'd1);
    check("full_sb_empty", 32'(sb_q.size()), 32'd0);
    check("full_err", 32'(err), 32'd0);
    check("full_exp_q", 32'(exp_q), 32'd1);

    // Fault injection: q stuck at 0.
    do_reset();
    fault_en = 1'b1;
    fault_val = 1'b0;
    push_cmd(C_SET, 2'b10, 1'b1, dummy);
    push_cmd(C_SET, 2'b10, 1'b1, dummy);
    wait_idle();
    check("fault_err", 32'(err), 32'd1);
    check("fault_err_count", 32'(err_count), 32'd2);
    repeat (4) @(negedge clk);
    check("fault_err_sticky", 32'(err), 32'd1);

    // Saturation at all-ones with a 2-bit counter.
    do_reset();
    check("sat_rst_err_count", 32'(err_count), 32'd0);
    check("sat_rst_err", 32'(err), 32'd0);
    for (int i = 0; i < 5; i++) push_cmd(C_SET, 2'b10, 1'b1, dummy);
    wait_idle();
    check("sat_err_count", 32'(err_count), 32'd3);
    check("sat_err", 32'(err), 32'd1);
    fault_en = 1'b0;

    // Reset during DRIVE of a TOGGLE with two commands queued.
    do_reset();
    push_cmd(C_CLR, 2'b01, 1'b0, dummy);
    push_cmd(C_TOG, 2'b11, 1'b1, dummy);
    push_cmd(C_SET, 2'b10, 1'b1, dummy);
    push_cmd(C_SET, 2'b10, 1'b1, dummy);
    check("mid_toggle_drive", 32'({j, k}), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_jk", 32'({j, k}), 32'd0);
    check("mid_rst_exp_q", 32'(exp_q), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    reset = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if ({j, k} != 2'b00) pulses++;
    end
    check("mid_no_pulses", 32'(pulses), 32'd0);
    check("mid_busy_after", 32'(busy), 32'd0);
    check("mid_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jk_cmd_driver.md
# jk_cmd_driver

Upstream stimulus and self-check stage for the JK flip-flop with asynchronous reset. Accepts JK commands over a valid/ready handshake, buffers them in a small FIFO, and drives the flip-flop's `j`/`k` inputs one command at a time. After each command it compares the flip-flop's `q` against an internally tracked expected value and counts mismatches. This lets the flip-flop run in-system without a hand-timed bench.

## Interface
- `DEPTH`, default 4: command FIFO depth; power of two, ≥ 2.
- `ERR_W`, default 8: width of the mismatch counter.

- `clk`  in  1: single clock, rising-edge.
- `reset`  in  1: synchronous, active-high; the same net also drives the flip-flop's reset.
- `cmd_valid`  in  1: command present.
- `cmd`  in  2: 00 HOLD, 01 CLR (j=0,k=1), 10 SET (j=1,k=0), 11 TOGGLE (j=1,k=1).
- `cmd_ready`  out  1: FIFO can accept; equals !full.
- `j`  out  1: registered, to the flip-flop.
- `k`  out  1: registered, to the flip-flop.
- `q_in`  in  1: flip-flop output `q`.
- `exp_q`  out  1: expected flip-flop state.
- `busy`  out  1: FIFO non-empty or state ≠ IDLE.
- `err`  out  1: sticky mismatch flag.
- `err_count`  out  ERR_W: number of mismatches, saturating at all-ones.

## Operation
- Push: a command is accepted when `cmd_valid && cmd_ready` at a rising edge.
  - Full FIFO: `cmd_ready`=0, so nothing is accepted, even if a pop happens the same cycle.
- States:
  - IDLE: if the FIFO is non-empty, pop the head, load j/k from it, and go to DRIVE. Otherwise stay, with j=k=0.
  - DRIVE: j/k hold the command for exactly one cycle. The flip-flop samples them at the closing edge. At that same edge, update `exp_q`:
    - HOLD: unchanged.
    - CLR: 0.
    - SET: 1.
    - TOGGLE: !`exp_q`.

    Also force j=k=0 and go to CHECK.
  - CHECK: compare `q_in` with `exp_q`. On mismatch, set `err`=1 and increment `err_count` (saturating). Then:
    - FIFO non-empty: pop, load j/k, and go to DRIVE (back-to-back).
    - FIFO empty: go to IDLE.
- j and k are never both driven from a stale command. Outside DRIVE, j=k=0.
- HOLD commands still take a DRIVE+CHECK slot and are still checked.

## Timing
- Reset values: `j`=0, `k`=0, `exp_q`=0, `err`=0, `err_count`=0, `busy`=0, `cmd_ready`=1, state=IDLE, FIFO empty.
- Reset mid-operation: at the next edge the FIFO is flushed, any in-flight command is dropped, and all outputs return to their reset values. The flip-flop is cleared by the same reset, so `exp_q`=0 stays consistent with it.
- Latency, push to j/k: a command pushed at edge E into an empty FIFO while in IDLE is popped at E+1, so j/k are visible after E+1.
  - DRIVE occupies E+1→E+2; `q_in` is checked during E+2→E+3.
- Throughput: one command per 2 cycles (DRIVE, CHECK).
- `err`/`err_count` update at the edge that ends CHECK.
- Simultaneous push and pop on a non-full FIFO: both occur, and the count is unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally. Full and empty are told apart by a count of log2(DEPTH)+1 bits.

## Structure
- Package `jk_pkg`:
  - `jk_cmd_t` enum (HOLD, CLR, SET, TOGGLE) and its 2-bit encoding.
  - `drv_state_t` enum (IDLE, DRIVE, CHECK).
  - A function mapping `jk_cmd_t` to {j,k}.
- Sub-module `jk_cmd_fifo`: synchronous FIFO with DEPTH/width parameters, synchronous active-high reset, push/pop, full/empty.
- Top: FSM, j/k registers, expected-value model, error counter.

## Test plan
- Reset: hold `reset`=1 for 3 cycles → `j`=`k`=0, `exp_q`=0, `err_count`=0, `cmd_ready`=1, `busy`=0.
- Sequence with a correct flip-flop: push SET, TOGGLE, TOGGLE, CLR, HOLD back-to-back → j/k pulses of 10, 11, 11, 01, 00 on alternate cycles; `exp_q` goes 1, 0, 1, 0, 0; `err`=0.
- Full FIFO: hold `cmd_valid`=1 with DEPTH=4 while the FSM is stalled by continuous pushes → `cmd_ready`=0 after 4 buffered commands; no command is lost or duplicated; all 4 (plus the one in flight) are driven in order.
- Fault injection: force `q_in`=0 and push SET, then SET again → `err`=1, `err_count`=2; `err` stays 1 after the FIFO drains.
- Saturation: with ERR_W=2, inject 5 mismatches → `err_count`=3.
- Reset mid-operation: assert `reset` during DRIVE of a TOGGLE with 2 commands queued → next cycle `j`=`k`=0, FIFO empty, `exp_q`=0, `busy`=0; no further j/k pulses after release.
